// File: rtl/i2s_pkg.sv
// rtl/i2s_pkg.sv - shared constants, channel encoding and stereo pair type for the I2S transmit path
package i2s_pkg;

  localparam int I2S_SLOTS    = 32;
  localparam int I2S_BCLK_DIV = 4;
  localparam int I2S_WORD_W   = 32;

  typedef enum logic {
    CH_LEFT  = 1'b0,
    CH_RIGHT = 1'b1
  } i2s_ch_e;

  // Samples sit right-aligned in a full slot-width word so any legal SAMPLE_W fits.
  typedef struct packed {
    logic [I2S_WORD_W-1:0] l;
    logic [I2S_WORD_W-1:0] r;
  } i2s_pair_t;

endpackage

// File: rtl/i2s_sample_buf.sv
// rtl/i2s_sample_buf.sv - one-pair holding register with valid/ready handshake and sticky underrun flag
module i2s_sample_buf
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic [SAMPLE_W-1:0] sample_l_i,
  input  logic [SAMPLE_W-1:0] sample_r_i,
  input  logic                sample_valid_i,
  output logic                sample_ready_o,
  input  logic                frame_start_i,
  input  logic                underrun_clr_i,
  output logic                underrun_o,
  output logic                hold_full_o,
  output i2s_pair_t           hold_pair_o
);

  logic      full_q, full_d;
  logic      und_q, und_d;
  logic      accept;
  i2s_pair_t pair_q, pair_d;

  assign sample_ready_o = ~full_q;
  assign accept         = sample_valid_i & ~full_q;

  always_comb begin
    full_d = full_q;
    pair_d = pair_q;
    und_d  = und_q;
    if (frame_start_i) full_d = 1'b0;
    // Accept is gated by the pre-edge flag, so a frame-start pair lands here, never in the active frame.
    if (accept) begin
      full_d   = 1'b1;
      pair_d.l = I2S_WORD_W'(sample_l_i);
      pair_d.r = I2S_WORD_W'(sample_r_i);
    end
    if (underrun_clr_i) und_d = 1'b0;
    if (frame_start_i && !full_q) und_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      full_q <= 1'b0;
      und_q  <= 1'b0;
      pair_q <= '0;
    end else begin
      full_q <= full_d;
      und_q  <= und_d;
      pair_q <= pair_d;
    end
  end

  assign underrun_o  = und_q;
  assign hold_full_o = full_q;
  assign hold_pair_o = pair_q;

endmodule

// File: rtl/i2s_tx_serializer.sv
// rtl/i2s_tx_serializer.sv - stereo I2S transmitter: bit clock, word clock alignment and MSB-first slot data
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int SLOT_W   = I2S_SLOTS
) (
  input  logic                clk_in,
  input  logic                rst_n,
  input  logic                lr_clk,
  input  logic [SAMPLE_W-1:0] sample_l,
  input  logic [SAMPLE_W-1:0] sample_r,
  input  logic                sample_valid,
  output logic                sample_ready,
  input  logic                underrun_clr,
  output logic                bclk_out,
  output logic                lrclk_out,
  output logic                sdata_out,
  output logic                underrun
);

  localparam int              PH_W      = $clog2(I2S_BCLK_DIV);
  localparam logic [PH_W-1:0] PH_LAST   = PH_W'(I2S_BCLK_DIV - 1);
  localparam logic [4:0]      SLOT_LAST = 5'(SLOT_W - 1);
  localparam logic [4:0]      LSB_SLOT  = 5'(SAMPLE_W);

  logic                  lr_q;
  logic [PH_W-1:0]       ph_q, ph_d;
  logic [4:0]            slot_q, slot_d;
  i2s_ch_e               ch_q, ch_d;
  i2s_pair_t             act_q, act_d;
  logic                  bclk_q, sdata_q, sdata_d;
  logic                  lr_edge, frame_start, hold_full;
  i2s_pair_t             hold_pair;
  logic [I2S_WORD_W-1:0] word;
  logic [4:0]            bit_idx;

  assign lr_edge     = lr_clk != lr_q;
  assign frame_start = lr_edge & ~lr_clk;

  i2s_sample_buf #(
    .SAMPLE_W(SAMPLE_W)
  ) u_buf (
    .clk_i         (clk_in),
    .rst_n_i       (rst_n),
    .sample_l_i    (sample_l),
    .sample_r_i    (sample_r),
    .sample_valid_i(sample_valid),
    .sample_ready_o(sample_ready),
    .frame_start_i (frame_start),
    .underrun_clr_i(underrun_clr),
    .underrun_o    (underrun),
    .hold_full_o   (hold_full),
    .hold_pair_o   (hold_pair)
  );

  always_comb begin
    ph_d   = ph_q + PH_W'(1);
    slot_d = slot_q;
    ch_d   = ch_q;
    act_d  = act_q;
    if (ph_q == PH_LAST && slot_q != SLOT_LAST) slot_d = slot_q + 5'd1;
    if (lr_edge) begin
      ph_d   = '0;
      slot_d = '0;
      ch_d   = i2s_ch_e'(lr_clk);
      if (frame_start) act_d = hold_full ? hold_pair : '0;
    end
    // Outputs are built from next state so the output register adds no visible slot delay.
    word    = (ch_d == CH_RIGHT) ? act_d.r : act_d.l;
    bit_idx = LSB_SLOT - slot_d;
    sdata_d = (slot_d != 5'd0 && slot_d <= LSB_SLOT) ? word[bit_idx] : 1'b0;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      lr_q    <= 1'b0;
      ph_q    <= '0;
      slot_q  <= SLOT_LAST;
      ch_q    <= CH_LEFT;
      act_q   <= '0;
      bclk_q  <= 1'b0;
      sdata_q <= 1'b0;
    end else begin
      lr_q    <= lr_clk;
      ph_q    <= ph_d;
      slot_q  <= slot_d;
      ch_q    <= ch_d;
      act_q   <= act_d;
      bclk_q  <= ph_d[PH_W-1];
      sdata_q <= sdata_d;
    end
  end

  assign bclk_out  = bclk_q;
  assign lrclk_out = ch_q;
  assign sdata_out = sdata_q;

endmodule

// File: tb/tb_i2s_tx_serializer.sv
// tb/tb_i2s_tx_serializer.sv - randomized self-checking bench against a timeline-based I2S reference model
module tb_i2s_tx_serializer;

  localparam int SW = 16;

  logic          clk_in = 1'b0;
  logic          rst_n = 1'b0;
  logic          lr_clk = 1'b0;
  logic          sample_valid = 1'b0;
  logic          underrun_clr = 1'b0;
  logic [SW-1:0] sample_l = '0;
  logic [SW-1:0] sample_r = '0;
  logic          sample_ready, bclk_out, lrclk_out, sdata_out, underrun;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in = ~clk_in;

  i2s_tx_serializer #(
    .SAMPLE_W(SW),
    .SLOT_W  (32)
  ) dut (
    .clk_in      (clk_in),
    .rst_n       (rst_n),
    .lr_clk      (lr_clk),
    .sample_l    (sample_l),
    .sample_r    (sample_r),
    .sample_valid(sample_valid),
    .sample_ready(sample_ready),
    .underrun_clr(underrun_clr),
    .bclk_out    (bclk_out),
    .lrclk_out   (lrclk_out),
    .sdata_out   (sdata_out),
    .underrun    (underrun)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle", tag, got, exp);
    end
  endtask

  // Reference model: outputs follow from elapsed cycles since the last word-clock edge.
  int            cyc = 0;
  int            ref_cyc = 0;
  bit            started = 0;
  bit            since_rst = 1;
  bit            m_ch = 0;
  bit            prev_lr = 0;
  bit            hold_v = 0;
  bit            m_und = 0;
  bit            acc_last = 0;
  logic [SW-1:0] act_l = '0, act_r = '0, hold_l = '0, hold_r = '0;
  int            dut_acc = 0;

  function automatic logic [4:0] expect_outs();
    int            d;
    int            k;
    logic [SW-1:0] w;
    logic          sd;
    d  = cyc - ref_cyc - 1;
    k  = since_rst ? 31 : ((d / 4 > 31) ? 31 : d / 4);
    w  = m_ch ? act_r : act_l;
    sd = (k >= 1 && k <= SW) ? w[SW-k] : 1'b0;
    return {((d % 4) >= 2), m_ch, sd, m_und, ~hold_v};
  endfunction

  task automatic model_update();
    bit lr_edge, fall, acc;
    if (!rst_n) begin
      started   = 1;
      since_rst = 1;
      ref_cyc   = cyc;
      m_ch      = 0;
      prev_lr   = 0;
      act_l     = '0;
      act_r     = '0;
      hold_v    = 0;
      m_und     = 0;
      acc_last  = 0;
      return;
    end
    lr_edge = (lr_clk != prev_lr);
    fall    = lr_edge && !lr_clk;
    acc     = sample_valid && !hold_v;
    if (lr_edge) begin
      ref_cyc   = cyc;
      since_rst = 0;
      m_ch      = lr_clk;
    end
    if (underrun_clr) m_und = 0;
    if (fall) begin
      if (hold_v) begin
        act_l  = hold_l;
        act_r  = hold_r;
        hold_v = 0;
      end else begin
        act_l = '0;
        act_r = '0;
        m_und = 1;
      end
    end
    if (acc) begin
      hold_l = sample_l;
      hold_r = sample_r;
      hold_v = 1;
    end
    acc_last = acc;
    prev_lr  = lr_clk;
  endtask

  task automatic step();
    if (rst_n && sample_valid && sample_ready) dut_acc++;
    model_update();
    @(posedge clk_in);
    #1;
    cyc++;
    if (started)
      check_eq("outs{bclk,lrclk,sdata,und,rdy}",
               {27'd0, bclk_out, lrclk_out, sdata_out, underrun, sample_ready},
               {27'd0, expect_outs()});
  endtask

  task automatic run_lr(input int n, input bit lr, input bit refill);
    lr_clk = lr;
    for (int i = 0; i < n; i++) begin
      step();
      if (refill && acc_last) begin
        sample_l = SW'($urandom);
        sample_r = SW'($urandom);
      end
    end
  endtask

  logic exp_msb;
  int   seg_len;

  initial begin
    rst_n = 1'b0;
    step();
    step();
    check_eq("rst_bclk", bclk_out, 0);
    check_eq("rst_lrclk", lrclk_out, 0);
    check_eq("rst_sdata", sdata_out, 0);
    check_eq("rst_underrun", underrun, 0);
    check_eq("rst_ready", sample_ready, 1);
    rst_n = 1'b1;
    run_lr(21, 0, 0);

    sample_l = 16'hA5F0;
    sample_r = 16'h0001;
    sample_valid = 1'b1;
    step();
    sample_valid = 1'b0;
    check_eq("ready_after_push", sample_ready, 0);
    run_lr(128, 1, 0);
    check_eq("no_underrun_on_rise", underrun, 0);
    lr_clk = 1'b0;
    step();
    check_eq("lrclk_e1", lrclk_out, 0);
    check_eq("sdata_e1", sdata_out, 0);
    repeat (3) step();
    check_eq("slot0_e4", sdata_out, 0);
    step();
    check_eq("msb_e5", sdata_out, 1);
    check_eq("ready_after_xfer", sample_ready, 1);
    repeat (60) step();
    check_eq("l_lsb_e65", sdata_out, 0);
    run_lr(63, 0, 0);
    lr_clk = 1'b1;
    repeat (65) step();
    check_eq("r_lsb_e65", sdata_out, 1);
    repeat (4) step();
    check_eq("r_pad_e69", sdata_out, 0);
    run_lr(59, 1, 0);

    run_lr(128, 0, 0);
    check_eq("underrun_set", underrun, 1);
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check_eq("underrun_clr", underrun, 0);
    run_lr(128, 1, 0);
    lr_clk = 1'b0;
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check_eq("clr_vs_set", underrun, 1);
    run_lr(127, 0, 0);
    run_lr(128, 1, 0);

    dut_acc = 0;
    sample_l = SW'($urandom);
    sample_r = SW'($urandom);
    sample_valid = 1'b1;
    run_lr(1, 1, 1);
    check_eq("bp_ready_drop", sample_ready, 0);
    for (int f = 0; f < 8; f++) begin
      run_lr(128, 0, 1);
      run_lr(128, 1, 1);
    end
    sample_valid = 1'b0;
    check_eq("bp_accepts", dut_acc, 9);

    exp_msb = hold_r[SW-1];
    lr_clk = 1'b0;
    repeat (42) step();
    lr_clk = 1'b1;
    step();
    check_eq("early_lrclk", lrclk_out, 1);
    repeat (4) step();
    check_eq("early_msb_e5", sdata_out, exp_msb);
    run_lr(100, 1, 0);

    for (int s = 0; s < 26; s++) begin
      seg_len = (s == 13) ? 200 : $urandom_range(30, 140);
      lr_clk = ~lr_clk;
      for (int i = 0; i < seg_len; i++) begin
        sample_valid = 1'($urandom_range(0, 1));
        sample_l     = SW'($urandom);
        sample_r     = SW'($urandom);
        underrun_clr = ($urandom_range(0, 49) == 0);
        step();
      end
    end
    sample_valid = 1'b0;
    underrun_clr = 1'b0;

    sample_l = 16'hFFFF;
    sample_r = 16'hFFFF;
    run_lr(130, 1, 0);
    sample_valid = 1'b1;
    run_lr(20, 0, 0);
    rst_n = 1'b0;
    step();
    check_eq("midrst_bclk", bclk_out, 0);
    check_eq("midrst_lrclk", lrclk_out, 0);
    check_eq("midrst_sdata", sdata_out, 0);
    check_eq("midrst_underrun", underrun, 0);
    rst_n = 1'b1;
    sample_valid = 1'b0;
    run_lr(10, 0, 0);
    run_lr(128, 1, 0);
    run_lr(64, 0, 0);
    check_eq("post_rst_underrun", underrun, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/i2s_tx_serializer.md
# i2s_tx_serializer

Stereo I2S transmit serializer for the audio codec path. It consumes the divided left/right word clock from the LR clock divider (`clk_in`/256, 128 cycles high and 128 low) and buffers one stereo 16-bit sample pair. It generates the bit clock (`clk_in`/4, 64 bits per frame) and drives the codec serial data line in standard I2S format: MSB one bit clock after the word-clock edge, 32-bit slots, 16 data bits followed by zero padding.

## Interface
Parameters:
- `SAMPLE_W`, default 16: sample width, legal range 1..31.
- `SLOT_W`, default 32: bit clocks per channel slot. Fixed by the divider ratio (256 / 4 / 2).

Ports:
- `clk_in` in 1: system clock, 50 MHz. Single clock domain.
- `rst_n` in 1: synchronous, active-low reset.
- `lr_clk` in 1: word clock from the divider, driven by a register on `clk_in`, so no synchronizer is needed. 0 = left, 1 = right.
- `sample_l` in `SAMPLE_W`: left sample, two's complement.
- `sample_r` in `SAMPLE_W`: right sample, two's complement.
- `sample_valid` in 1: producer offers a pair.
- `sample_ready` out 1: block can accept a pair.
- `underrun_clr` in 1: clears `underrun`.
- `bclk_out` out 1: codec bit clock.
- `lrclk_out` out 1: codec word clock, aligned to `sdata_out`.
- `sdata_out` out 1: codec serial data.
- `underrun` out 1: sticky flag, set when a frame starts with no pair buffered.

## Operation
- **Edge detect.** `lr_q` registers `lr_clk`. An edge is `lr_clk != lr_q`. On an edge: `ph` <= 0, `slot` <= 0, `lrclk_out` <= `lr_clk`.
- **Bit phase.** `ph` (2 bits) increments every cycle. `bclk_out` = `ph[1]`: low for ph 0–1, high for ph 2–3. Data changes only when `ph` wraps 3→0, which is the `bclk_out` falling edge.
- **Slot counter.** `slot` (5 bits) increments on each `ph` wrap and saturates at 31 if the next edge is late.
- **Data per slot.** Slot 0 is always 0. Slots 1..`SAMPLE_W` carry sample bits MSB..LSB. Remaining slots are 0.
- **Buffering.** A holding register (`hold_l`, `hold_r`, `hold_full`) and an active register (`act_l`, `act_r`).
  - `sample_ready` = `~hold_full`, combinational.
  - A pair is accepted when `sample_valid & sample_ready`, which sets `hold_full`.
- **Falling `lr_clk` edge (frame start).**
  - If `hold_full`: hold moves to act and `hold_full` clears.
  - Otherwise: act <= 0 and `underrun` <= 1.
  - The left slot shifts `act_l`.
- **Rising `lr_clk` edge.** The right slot shifts `act_r`. The holding register is untouched.
- **Edge and accept in the same cycle.** `ready` reflects the pre-edge `hold_full`.
  - If the buffer was full, no accept occurs that cycle.
  - If the buffer was empty, the accepted pair goes to hold, not act. It plays next frame, and the current frame underruns.
- **`underrun_clr`.** Clears the flag. If `underrun_clr` and a set condition occur in the same cycle, set wins.
- **Early edge.** An edge arriving before slot 31 truncates the current slot and restarts at slot 0. No error is flagged.
- **No edges.** `ph` free-runs, `slot` saturates, and `sdata_out` stays 0.

## Timing
- **Reset values (while `rst_n` low, one clock):** `bclk_out` 0, `lrclk_out` 0, `sdata_out` 0, `underrun` 0, `hold_full` 0, `ph` 0, `slot` 31, `lr_q` 0. Handshake inputs are ignored during reset.
- **Reset mid-frame.** Output is abandoned immediately. The first frame after reset starts at the next falling `lr_clk` edge.
- **Edge alignment.** Edge seen at cycle E, then `lrclk_out` toggles at E+1 with `sdata_out` = 0 (slot 0).
- **MSB timing.** MSB appears at E+5 and is held 4 cycles. The LSB (16-bit) occupies cycles E+65..E+68.
- **Register stage.** `bclk_out`, `lrclk_out` and `sdata_out` are all register outputs, with one cycle of latency from the internal state.
- **Throughput.** One pair per 256 `clk_in` cycles, with one-pair buffering ahead of the active frame.

## Structure
- **Shared package `i2s_pkg`** holds:
  - `I2S_SLOTS` = 32, `I2S_BCLK_DIV` = 4.
  - The channel encoding: `CH_LEFT` = 0, `CH_RIGHT` = 1.
  - The stereo pair struct.
- **Optional sub-module `i2s_sample_buf`:** the holding register plus handshake and underrun logic. The serializer core stays flat.

## Test plan
- **Basic frame.** After reset, push L=16'hA5F0, R=16'h0001, then drive `lr_clk` with a 256-cycle period.
  - Left slot sends 0, then 1010_0101_1111_0000, then 15 zeros.
  - Right slot sends 0001 in slots 1–16.
  - MSB appears at E+5.
- **Bit clock.** Check `bclk_out` has period 4 and is low for the 2 cycles after reset/edge. Every `sdata_out` change coincides with a `bclk_out` falling edge.
- **Underrun.**
  - No pair pushed: frame is all zeros and `underrun` = 1.
  - Pulse `underrun_clr`: flag reads 0 next cycle.
  - Clear together with a new underrun: flag stays 1.
- **Backpressure.** Hold `sample_valid` high with incrementing data.
  - `sample_ready` deasserts after the first accept and reasserts one cycle after each falling-edge transfer.
  - No pair is skipped or duplicated over 8 frames.
- **Early edge / reset.**
  - Toggle `lr_clk` at slot 10: restarts at slot 0 with the new channel's MSB at E+5.
  - Assert `rst_n` low mid-word: all outputs are 0 the next cycle.
